// File: rtl/gelato_alu_arbiter.sv
// Round-robin arbiter and task sequencer sharing one ALU among NUM_REQ requesters.
// Optional BUSY watchdog is built when GELATO_ALU_ARB_TIMEOUT_EN is defined.
module gelato_alu_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int OP_WIDTH   = 5
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              rdy_i,
   input  logic [NUM_REQ-1:0]                req_valid_i,
   output logic [NUM_REQ-1:0]                req_ready_o,
   input  logic [NUM_REQ*OP_WIDTH-1:0]       req_op_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_rs1_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_rs2_i,
   output logic                              resp_valid_o,
   output logic [$clog2(NUM_REQ)-1:0]        resp_id_o,
   output logic [DATA_WIDTH-1:0]             resp_rd_o,
   output logic                              alu_valid_o,
   output logic [OP_WIDTH-1:0]               alu_op_o,
   output logic [DATA_WIDTH-1:0]             alu_rs1_o,
   output logic [DATA_WIDTH-1:0]             alu_rs2_o,
   input  logic                              alu_done_i,
   input  logic [DATA_WIDTH-1:0]             alu_rd_i,
   output logic                              err_timeout_o
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam logic [IDW:0]   NUM_REQ_W = NUM_REQ[IDW:0];
   localparam logic [IDW-1:0] LAST_IDX  = IDW'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]          cur_id_q, cur_id_d;
   logic                    alu_valid_q, alu_valid_d;
   logic [OP_WIDTH-1:0]     alu_op_q, alu_op_d;
   logic [DATA_WIDTH-1:0]   alu_rs1_q, alu_rs1_d;
   logic [DATA_WIDTH-1:0]   alu_rs2_q, alu_rs2_d;
   logic                    resp_valid_q, resp_valid_d;
   logic [IDW-1:0]          resp_id_q, resp_id_d;
   logic [DATA_WIDTH-1:0]   resp_rd_q, resp_rd_d;
`ifdef GELATO_ALU_ARB_TIMEOUT_EN
   logic [7:0]              tmo_cnt_q, tmo_cnt_d;
   logic                    err_q, err_d;
`endif

   logic                    gnt_found_s;
   logic [IDW-1:0]          gnt_idx_s;
   logic [IDW:0]            cand_s;
   logic                    grant_s;

   // Cyclic search for the first pending requester at or after rr_ptr.
   always_comb begin
      gnt_found_s = 1'b0;
      gnt_idx_s   = '0;
      cand_s      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand_s = {1'b0, rr_ptr_q} + (IDW+1)'(i);
         if (cand_s >= NUM_REQ_W) begin
            cand_s = cand_s - NUM_REQ_W;
         end else begin
            cand_s = cand_s;
         end
         if (!gnt_found_s && req_valid_i[cand_s[IDW-1:0]]) begin
            gnt_found_s = 1'b1;
            gnt_idx_s   = cand_s[IDW-1:0];
         end else begin
            gnt_found_s = gnt_found_s;
         end
      end
   end

   assign grant_s = (state_q == IDLE) && rdy_i && gnt_found_s;

   // State register: every register holds while rdy_i is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         cur_id_q     <= '0;
         alu_valid_q  <= 1'b0;
         alu_op_q     <= '0;
         alu_rs1_q    <= '0;
         alu_rs2_q    <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_rd_q    <= '0;
`ifdef GELATO_ALU_ARB_TIMEOUT_EN
         tmo_cnt_q    <= 8'd0;
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         cur_id_q     <= cur_id_d;
         alu_valid_q  <= alu_valid_d;
         alu_op_q     <= alu_op_d;
         alu_rs1_q    <= alu_rs1_d;
         alu_rs2_q    <= alu_rs2_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_rd_q    <= resp_rd_d;
`ifdef GELATO_ALU_ARB_TIMEOUT_EN
         tmo_cnt_q    <= tmo_cnt_d;
         err_q        <= err_d;
`endif
      end
   end

   // Next-state logic for the FSM and its datapath registers.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      cur_id_d     = cur_id_q;
      alu_valid_d  = alu_valid_q;
      alu_op_d     = alu_op_q;
      alu_rs1_d    = alu_rs1_q;
      alu_rs2_d    = alu_rs2_q;
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      resp_rd_d    = resp_rd_q;
`ifdef GELATO_ALU_ARB_TIMEOUT_EN
      tmo_cnt_d    = tmo_cnt_q;
      err_d        = err_q;
`endif
      if (rdy_i) begin
         resp_valid_d = 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_s) begin
                  alu_op_d    = req_op_i[int'(gnt_idx_s)*OP_WIDTH +: OP_WIDTH];
                  alu_rs1_d   = req_rs1_i[int'(gnt_idx_s)*DATA_WIDTH +: DATA_WIDTH];
                  alu_rs2_d   = req_rs2_i[int'(gnt_idx_s)*DATA_WIDTH +: DATA_WIDTH];
                  alu_valid_d = 1'b1;
                  cur_id_d    = gnt_idx_s;
                  rr_ptr_d    = (gnt_idx_s == LAST_IDX) ? '0 : gnt_idx_s + IDW'(1);
                  state_d     = BUSY;
`ifdef GELATO_ALU_ARB_TIMEOUT_EN
                  tmo_cnt_d   = 8'd0;
`endif
               end else begin
                  state_d = IDLE;
               end
            end
            BUSY: begin
               if (alu_done_i) begin
                  resp_rd_d    = alu_rd_i;
                  resp_id_d    = cur_id_q;
                  resp_valid_d = 1'b1;
                  alu_valid_d  = 1'b0;
                  state_d      = DRAIN;
`ifdef GELATO_ALU_ARB_TIMEOUT_EN
               end else if (tmo_cnt_q == 8'd254) begin
                  // Abandon the task silently; the flag stays up until reset.
                  tmo_cnt_d   = 8'd255;
                  err_d       = 1'b1;
                  alu_valid_d = 1'b0;
                  state_d     = DRAIN;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + 8'd1;
`else
               end else begin
                  state_d = BUSY;
`endif
               end
            end
            DRAIN: begin
               if (!alu_done_i) begin
                  state_d = IDLE;
               end else begin
                  state_d = DRAIN;
               end
            end
            default: begin
               state_d     = IDLE;
               alu_valid_d = 1'b0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Output decode: one-hot combinational grant.
   always_comb begin
      req_ready_o = '0;
      if (grant_s) begin
         req_ready_o[gnt_idx_s] = 1'b1;
      end else begin
         req_ready_o = '0;
      end
   end

   assign resp_valid_o = resp_valid_q;
   assign resp_id_o    = resp_id_q;
   assign resp_rd_o    = resp_rd_q;
   assign alu_valid_o  = alu_valid_q;
   assign alu_op_o     = alu_op_q;
   assign alu_rs1_o    = alu_rs1_q;
   assign alu_rs2_o    = alu_rs2_q;
`ifdef GELATO_ALU_ARB_TIMEOUT_EN
   assign err_timeout_o = err_q;
`else
   assign err_timeout_o = 1'b0;
`endif

endmodule

// File: doc/gelato_alu_arbiter.md
# gelato_alu_arbiter

Round-robin arbiter and sequencer that shares one `gelato_arith_logic_unit` among `NUM_REQ` requesters (warp lanes or issue slots). It accepts one operation at a time and drives the ALU task handshake (`valid`/`done`). It returns `rd` to the originating requester as a one-cycle tagged response. It sits between the issue stage and the ALU and owns all sequencing of ALU tasks.

## Interface
- `NUM_REQ`, 4, number of requesters (2..16)
- `DATA_WIDTH`, 32, operand/result width
- `OP_WIDTH`, 5, ALU opcode width (`gelato_types` ALU op encoding)
- `clk` input 1 clock, all logic on rising edge
- `rst_n` input 1 reset, asynchronous, active-low
- `rdy` input 1 global enable; low freezes FSM, pointer and outputs
- `req_valid` input NUM_REQ per-requester operation pending
- `req_ready` output NUM_REQ one-hot grant, combinational
- `req_op` input NUM_REQ*OP_WIDTH opcode, slice i for requester i
- `req_rs1`, `req_rs2` input NUM_REQ*DATA_WIDTH operands, slice i
- `resp_valid` output 1 result pulse, one cycle
- `resp_id` output $clog2(NUM_REQ) requester index of result
- `resp_rd` output DATA_WIDTH result value
- `alu_valid` output 1 task valid to ALU
- `alu_op` output OP_WIDTH ALU opcode
- `alu_rs1`, `alu_rs2` output DATA_WIDTH ALU operands
- `alu_done` input 1 ALU completion
- `alu_rd` input DATA_WIDTH ALU result
- `err_timeout` output 1 sticky watchdog flag (see Configuration)

## Operation
- States: IDLE, BUSY, DRAIN.
- **IDLE**
  - When `rdy` is high and any `req_valid` is set, `req_ready` asserts for the first requester at or after `rr_ptr`, searching cyclically upward. `req_ready` is 0 in every other state and whenever `rdy` is low.
  - On that edge the arbiter captures `op`/`rs1`/`rs2` into the `alu_*` registers, stores the grant index in `cur_id`, sets `rr_ptr` = grant+1 mod `NUM_REQ`, and moves to BUSY.
- **BUSY**
  - `alu_valid` is 1 and the operands are stable.
  - On an edge with `alu_done`=1, the arbiter latches `resp_rd` <= `alu_rd` and `resp_id` <= `cur_id`, sets `resp_valid` <= 1, sets `alu_valid` <= 0, and moves to DRAIN.
- **DRAIN**
  - `alu_valid` is 0.
  - When `alu_done`=0, the FSM moves to IDLE. While `alu_done` stays high, it stays in DRAIN and issues nothing.
  - The ALU must clear `done` after `valid` drops.
- `resp_valid` clears on the following enabled edge. There is no response backpressure; requesters must sample it.
- `req_valid` may drop before a grant; the request is then simply not served.
- Arbitration uses `rr_ptr` only. A requester holding `req_valid` is served within `NUM_REQ` grants.
- With `rdy` low, all registers hold their values and `resp_valid` holds its value; a grant cannot occur.
- An opcode is passed through unchanged; validation is the ALU's job.

## Timing
- Reset values are 0 for all of the following: `req_ready`, `resp_valid`, `resp_id`, `resp_rd`, `alu_valid`, `alu_op`, `alu_rs1`, `alu_rs2`, `err_timeout`. State = IDLE, `rr_ptr` = 0.
- Reset mid-operation abandons the in-flight task and produces no response.
- Sequence for an accept on edge E0, with the ALU raising `done` visible in cycle E0+k:
  - `alu_valid` is high from E0 to the capture edge.
  - `resp_valid` is high in the cycle after the edge that sampled `done`.
- Latency is k+1 edges from accept to `resp_valid`; k=2 for a single-cycle ALU op, giving 3 cycles.
- Next grant earliest: the cycle after DRAIN sees `alu_done`=0.
- Throughput is at most one op per (k+2) cycles.

## Configuration
- `GELATO_ALU_ARB_TIMEOUT_EN`
- **Defined**
  - An 8-bit counter resets on entry to BUSY and increments each enabled cycle in BUSY.
  - Reaching 255 sets `err_timeout` (sticky until reset), forces `alu_valid`=0, and moves to DRAIN with no response.
- **Undefined**
  - No counter is built, `err_timeout` is tied to 0, and BUSY waits indefinitely.

## Test plan
- **Single ADD:** reset, requester 2 sends ADD rs1=5 rs2=7; ALU model done after 2 cycles -> one `resp_valid` pulse with `resp_id`=2, `resp_rd`=12; `req_ready[2]` high exactly one cycle.
- **Round-robin fairness:** all 4 `req_valid` held continuously -> grant order 0,1,2,3,0; each result tagged with the correct id.
- **Pointer wrap:** after a grant to requester 3, requesters 0 and 3 both valid -> grant 0 next.
- **Stall:** `rdy` low for 5 cycles while in BUSY with `done` high -> no transition, no `resp_valid`; resumes on `rdy` high.
- **Sticky done:** ALU holds `done` 4 cycles after `valid` drops -> FSM stays in DRAIN, no new grant until `done`=0.
- **Timeout (macro defined):** ALU never raises `done` -> `err_timeout`=1 after 255 BUSY cycles, `alu_valid`=0, no response, next request still served.
